router_controller_np: RTL
=========================

Name: router_controller_np

Overview:
- Parametrised packet-router control FSM for one input port feeding NUM_PORTS output FIFOs. Successor of the fixed 1:3 controller.
- Decodes the header address and sequences the first-data, data, parity, FIFO-full and parity-check phases. Drives the load/strobe/busy signals consumed by the register and synchroniser blocks.
- Behaviour the fixed controller lacks:
  - invalid-address packet drop,
  - per-destination wait-for-empty,
  - bounded wait with timeout drop,
  - latched one-hot destination select.

Parameters:
- NUM_PORTS, 3, number of output FIFOs (2..16).
- ADDR_W, 2, header address field width; must satisfy 2**ADDR_W >= NUM_PORTS.
- WAIT_TIMEOUT, 256, max cycles in WAIT_TILL_EMPTY before the packet is dropped; 0 = wait forever.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- packet_valid  in  1  input packet framing
- data_in  in  ADDR_W  header address bits (data byte LSBs)
- fifo_empty  in  NUM_PORTS  per-FIFO empty flags
- fifo_full  in  1  full flag of the currently selected FIFO
- soft_reset  in  NUM_PORTS  per-FIFO read-timeout soft reset
- parity_done  in  1  parity byte captured (register block)
- low_packet_valid  in  1  packet_valid fell while full (register block)
- detect_add, lfd_state, ld_state, lp_state, laf_state, full_state, reset_int_reg  out  1 each  state decodes
- write_enb_reg  out  1  FIFO write enable
- busy  out  1  input-stall request to source
- drop_state  out  1  packet being discarded
- dest_sel  out  NUM_PORTS  one-hot of latched destination

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset state:
  - pre_state = DECODE_ADDRESS, dest_reg = 0, wait_cnt = 0.
  - Outputs after reset: detect_add=1, dest_sel=1, all other outputs 0.
- States use 4-bit encoding: DECODE_ADDRESS=0, LOAD_FIRST_DATA=1, LOAD_DATA=2, LOAD_PARITY=3, FIFO_FULL_STATE=4, LOAD_AFTER_FULL=5, WAIT_TILL_EMPTY=6, CHECK_PARITY_ERROR=7, DROP_PACKET=8. Any other encoding goes to DECODE_ADDRESS.
- Destination latch: dest_reg <= data_in only in DECODE_ADDRESS while packet_valid=1. dest_sel = 1<<dest_reg (registered, follows dest_reg).
- Transitions:
  - DECODE_ADDRESS: packet_valid=0 -> stay. If data_in >= NUM_PORTS -> DROP_PACKET. Else if fifo_empty[data_in] -> LOAD_FIRST_DATA, else WAIT_TILL_EMPTY.
  - LOAD_FIRST_DATA -> LOAD_DATA.
  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else packet_valid=0 -> LOAD_PARITY; else stay.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else DECODE_ADDRESS.
  - FIFO_FULL_STATE: fifo_full -> stay, else LOAD_AFTER_FULL.
  - LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_packet_valid -> LOAD_PARITY; else LOAD_DATA.
  - WAIT_TILL_EMPTY: fifo_empty[dest_reg] -> LOAD_FIRST_DATA. Only the addressed FIFO is checked. Else if WAIT_TIMEOUT != 0 and wait_cnt == WAIT_TIMEOUT-1 -> DROP_PACKET. Else stay.
  - DROP_PACKET: packet_valid=0 -> DECODE_ADDRESS, else stay.
- Soft-reset override: in any state except DECODE_ADDRESS and DROP_PACKET, soft_reset[dest_reg]=1 forces next state DECODE_ADDRESS. Priority: reset > soft reset > normal transition. soft_reset bits for other ports are ignored.
- wait_cnt:
  - Cleared on any cycle not in WAIT_TILL_EMPTY.
  - Increments each WAIT_TILL_EMPTY cycle; width clog2(WAIT_TIMEOUT+1).
  - Saturates and never wraps.
- Combinational outputs:
  - write_enb_reg = LD | LAF | LP.
  - busy = LFD | LP | FULL | LAF | WAIT | CHECK_PARITY_ERROR. busy=0 in DROP_PACKET, so the source drains the packet while bytes are discarded.
  - drop_state = (pre_state == DROP_PACKET).
  - The state decodes are one-hot of pre_state. All outputs are combinational from pre_state; zero-cycle latency from the state register.
- fifo_empty / fifo_full sampled combinationally every cycle. No glitch guarantees beyond the synchronous domain.

Optional Feature:
- Macro: ROUTER_CTRL_STATS_EN.
- Defined:
  - Adds outputs pkt_count[15:0], drop_count[15:0] and timeout_count[15:0].
  - pkt_count increments on CHECK_PARITY_ERROR entry.
  - drop_count increments on DROP_PACKET entry from any source.
  - timeout_count increments on WAIT_TILL_EMPTY -> DROP_PACKET only.
  - All counters cleared by reset and saturate at 16'hFFFF.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Defaults; fifo_empty=3'b111; packet_valid=1, data_in=2'b01 for 1 cycle then 4 payload cycles; packet_valid=0 -> states 0,1,2,2,2,2,3,7,0. dest_sel=3'b010. write_enb_reg high 5 cycles. busy high in LFD/LP/CPE.
- data_in=2'b11, NUM_PORTS=3, packet_valid high 6 cycles -> DROP_PACKET for 6 cycles, busy=0, write_enb_reg=0, then DECODE_ADDRESS.
- data_in=2'b10, fifo_empty=3'b011 -> WAIT_TILL_EMPTY. fifo_empty[0] toggling has no effect. fifo_empty[2]=1 at cycle 10 -> LOAD_FIRST_DATA next cycle.
- WAIT_TIMEOUT=8, fifo_empty[2]=0 held -> exactly 8 cycles in WAIT_TILL_EMPTY, then DROP_PACKET. With STATS_EN, timeout_count=1 and drop_count=1.
- In LOAD_DATA, fifo_full=1 for 3 cycles -> FIFO_FULL_STATE x3, then LAF. With low_packet_valid=1 -> LP -> CPE -> DECODE_ADDRESS.
- In FIFO_FULL_STATE with dest_reg=1, soft_reset=3'b100 -> no effect; soft_reset=3'b010 -> DECODE_ADDRESS next cycle. reset=1 in LOAD_DATA -> DECODE_ADDRESS, dest_sel=1 next cycle.

Source files
------------

// File: rtl/router_controller_np.sv
// router_controller_np: header decode and phase sequencing for one input port feeding NUM_PORTS output FIFOs.
// Latency: the state decodes, write_enb_reg, busy and drop_state are combinational from the state register (0 cycles); dest_sel follows the latched header one cycle after decode.
// Backpressure: busy stalls the source in LFD/LP/FULL/LAF/WAIT/CPE and is low in DROP_PACKET so the source drains a discarded packet.
//
// Optional feature: define ROUTER_CTRL_STATS_EN to add the pkt_count, drop_count and timeout_count outputs.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   packet_valid        input packet framing
//   data_in             header address bits (LSBs of the data byte)
//   fifo_empty          per-FIFO empty flags
//   fifo_full           full flag of the currently selected FIFO
//   soft_reset          per-FIFO read-timeout soft reset (only the latched destination's bit is used)
//   parity_done         parity byte captured by the register block
//   low_packet_valid    packet_valid fell while the FIFO was full (register block)
//   detect_add .. reset_int_reg   one-hot decodes of the current state
//   write_enb_reg       FIFO write enable
//   busy                input-stall request to the source
//   drop_state          packet is being discarded
//   dest_sel            one-hot of the latched destination (all zero for an out-of-range address)
//   pkt_count, drop_count, timeout_count   saturating statistics (ROUTER_CTRL_STATS_EN only)
module router_controller_np #(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 256
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 packet_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_packet_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 lp_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 reset_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic                 drop_state,
  output logic [NUM_PORTS-1:0] dest_sel
`ifdef ROUTER_CTRL_STATS_EN
  ,
  output logic [15:0]          pkt_count,
  output logic [15:0]          drop_count,
  output logic [15:0]          timeout_count
`endif
);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    LOAD_PARITY        = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    WAIT_TILL_EMPTY    = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;

  // With WAIT_TIMEOUT = 0 the counter is never compared, but keep it one bit wide.
  localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_TIMEOUT > 0) ? CNT_W'(WAIT_TIMEOUT - 1) : '0;

  state_t              pre_state;
  state_t              next_state;
  logic [ADDR_W-1:0]   dest_reg;
  logic [CNT_W-1:0]    wait_cnt;

  logic                addr_valid;
  logic                addr_empty;
  logic                dest_empty;
  logic                dest_soft_rst;

  // Addresses at or above NUM_PORTS have no FIFO behind them.
  assign addr_valid = ({1'b0, data_in} < (ADDR_W + 1)'(NUM_PORTS));

  // Per-port flag selection by loop so that out-of-range addresses read as 0
  // instead of indexing past the end of the flag vectors.
  always_comb begin
    addr_empty    = 1'b0;
    dest_empty    = 1'b0;
    dest_soft_rst = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_in == ADDR_W'(i)) begin
        addr_empty = fifo_empty[i];
      end
      if (dest_reg == ADDR_W'(i)) begin
        dest_empty    = fifo_empty[i];
        dest_soft_rst = soft_reset[i];
      end
    end
  end

  always_comb begin
    next_state = DECODE_ADDRESS;
    case (pre_state)
      DECODE_ADDRESS: begin
        if (!packet_valid)     next_state = DECODE_ADDRESS;
        else if (!addr_valid)  next_state = DROP_PACKET;
        else if (addr_empty)   next_state = LOAD_FIRST_DATA;
        else                   next_state = WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)         next_state = FIFO_FULL_STATE;
        else if (!packet_valid) next_state = LOAD_PARITY;
        else                   next_state = LOAD_DATA;
      end
      LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        if (fifo_full)         next_state = FIFO_FULL_STATE;
        else                   next_state = DECODE_ADDRESS;
      end
      FIFO_FULL_STATE: begin
        if (fifo_full)         next_state = FIFO_FULL_STATE;
        else                   next_state = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)           next_state = DECODE_ADDRESS;
        else if (low_packet_valid) next_state = LOAD_PARITY;
        else                       next_state = LOAD_DATA;
      end
      WAIT_TILL_EMPTY: begin
        // Only the addressed FIFO matters; other ports draining is irrelevant.
        if (dest_empty)
          next_state = LOAD_FIRST_DATA;
        else if ((WAIT_TIMEOUT != 0) && (wait_cnt == CNT_LAST))
          next_state = DROP_PACKET;
        else
          next_state = WAIT_TILL_EMPTY;
      end
      DROP_PACKET: begin
        if (!packet_valid)     next_state = DECODE_ADDRESS;
        else                   next_state = DROP_PACKET;
      end
      default: next_state = DECODE_ADDRESS;
    endcase

    // A read-side timeout on our destination abandons the packet in flight.
    // DECODE_ADDRESS has nothing to abandon and DROP_PACKET must keep draining.
    if ((pre_state != DECODE_ADDRESS) && (pre_state != DROP_PACKET) && dest_soft_rst)
      next_state = DECODE_ADDRESS;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_state <= DECODE_ADDRESS;
      dest_reg  <= '0;
      dest_sel  <= NUM_PORTS'(1);
      wait_cnt  <= '0;
    end else begin
      pre_state <= next_state;
      if ((pre_state == DECODE_ADDRESS) && packet_valid) begin
        dest_reg <= data_in;
        dest_sel <= NUM_PORTS'(1) << data_in;
      end
      // wait_cnt holds the number of WAIT_TILL_EMPTY cycles already spent.
      if (pre_state != WAIT_TILL_EMPTY)
        wait_cnt <= '0;
      else if (wait_cnt != CNT_MAX)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign detect_add    = (pre_state == DECODE_ADDRESS);
  assign lfd_state     = (pre_state == LOAD_FIRST_DATA);
  assign ld_state      = (pre_state == LOAD_DATA);
  assign lp_state      = (pre_state == LOAD_PARITY);
  assign laf_state     = (pre_state == LOAD_AFTER_FULL);
  assign full_state    = (pre_state == FIFO_FULL_STATE);
  assign reset_int_reg = (pre_state == CHECK_PARITY_ERROR);
  assign drop_state    = (pre_state == DROP_PACKET);

  assign write_enb_reg = ld_state | laf_state | lp_state;
  assign busy          = lfd_state | lp_state | full_state | laf_state |
                         (pre_state == WAIT_TILL_EMPTY) | reset_int_reg;

`ifdef ROUTER_CTRL_STATS_EN
  logic enter_cpe;
  logic enter_drop;
  logic wait_timeout;

  assign enter_cpe    = (next_state == CHECK_PARITY_ERROR) && (pre_state != CHECK_PARITY_ERROR);
  assign enter_drop   = (next_state == DROP_PACKET) && (pre_state != DROP_PACKET);
  assign wait_timeout = (next_state == DROP_PACKET) && (pre_state == WAIT_TILL_EMPTY);

  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_count     <= '0;
      drop_count    <= '0;
      timeout_count <= '0;
    end else begin
      if (enter_cpe && (pkt_count != 16'hFFFF))
        pkt_count <= pkt_count + 16'd1;
      if (enter_drop && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
      if (wait_timeout && (timeout_count != 16'hFFFF))
        timeout_count <= timeout_count + 16'd1;
    end
  end
`endif

endmodule
